// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for a multicycle datapath (FETCH/DECODE/EXEC/MEM/WB).
// Latency: R 4, LW 5, SW 4, BEQ 3, J 3, illegal 2 cycles; outputs are a combinational state decode.
// Backpressure: mem_ready low holds FETCH, MEMRD or MEMWR with strobes stable. Optional macro: MCCTRL_JUMP_EN.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             mem_ready,
  output logic [1:0]       aluop,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic [1:0]       pcsource,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8
`ifdef MCCTRL_JUMP_EN
    , S_JUMP = 4'd9
`endif
  } state_e;

  localparam logic [2:0] OP_R   = 3'b000;
  localparam logic [2:0] OP_LW  = 3'b001;
  localparam logic [2:0] OP_SW  = 3'b010;
  localparam logic [2:0] OP_BEQ = 3'b011;
`ifdef MCCTRL_JUMP_EN
  localparam logic [2:0] OP_J   = 3'b100;
`endif

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign state       = state_q;
  assign instr_count = cnt_q;
  assign cnt_d       = instr_done ? cnt_q + CNT_W'(1) : cnt_q;

  // State, latched opcode and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and datapath controls; everything except state is held at 0 during reset.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    aluop       = 2'b00;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    pcsource    = 2'b00;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcwrite = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          op_d    = opcode;
          case (opcode)
            OP_R:         state_d = S_EXEC;
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_BEQ:       state_d = S_BRANCH;
`ifdef MCCTRL_JUMP_EN
            OP_J:         state_d = S_JUMP;
`endif
            default: begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          regwrite   = 1'b1;
          memtoreg   = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          memwrite = 1'b1;
          iord     = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
          state_d = S_RWB;
        end
        S_RWB: begin
          regwrite   = 1'b1;
          regdst     = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BRANCH: begin
          alusrca     = 1'b1;
          aluop       = 2'b01;
          pcwritecond = 1'b1;
          pcsource    = 2'b01;
          instr_done  = 1'b1;
          state_d     = S_FETCH;
        end
`ifdef MCCTRL_JUMP_EN
        S_JUMP: begin
          pcwrite    = 1'b1;
          pcsource   = 2'b10;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
`endif
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: vector table, hand-written corner sequences and a
// randomized run against a queue-based instruction-sequence model.
// The counter is built 8 bits wide so the wrap case fits in a short run.
module tb_multicycle_ctrl;

  localparam int CW = 8;
`ifdef MCCTRL_JUMP_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    opcode = 3'b000;
  logic          mem_ready = 1'b0;
  logic [1:0]    aluop, alusrcb, pcsource;
  logic          alusrca, iord, memread, memwrite, irwrite, pcwrite, pcwritecond;
  logic          regwrite, regdst, memtoreg, instr_done, illegal;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;
  logic [17:0]   obs;

  int total = 0;
  int bad   = 0;
  int mcnt  = 0;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .aluop(aluop), .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
    .pcwritecond(pcwritecond), .pcsource(pcsource), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .state(state), .instr_done(instr_done),
    .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs = {aluop, alusrca, alusrcb, iord, memread, memwrite, irwrite, pcwrite,
                pcwritecond, pcsource, regwrite, regdst, memtoreg, instr_done, illegal};

  function automatic bit legal_op(input logic [2:0] op);
    return (op <= 3'd3) || (JEN && op == 3'd4);
  endfunction

  // Expected control outputs of each state, straight from the state descriptions.
  function automatic logic [17:0] exp_out(input int st, input logic rdy, input logic [2:0] op);
    logic [1:0] a_op = 2'b00, srcb = 2'b00, pcs = 2'b00;
    logic srca = 0, io = 0, mr = 0, mw = 0, irw = 0, pcw = 0, pcc = 0;
    logic rw = 0, rd = 0, m2r = 0, dn = 0, il = 0;
    case (st)
      0: begin mr = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      1: begin srcb = 2'b11; il = !legal_op(op); end
      2: begin srca = 1; srcb = 2'b10; end
      3: begin mr = 1; io = 1; end
      4: begin rw = 1; m2r = 1; dn = 1; end
      5: begin mw = 1; io = 1; dn = rdy; end
      6: begin srca = 1; a_op = 2'b10; end
      7: begin rw = 1; rd = 1; dn = 1; end
      8: begin srca = 1; a_op = 2'b01; pcc = 1; pcs = 2'b01; dn = 1; end
      9: begin pcw = 1; pcs = 2'b10; dn = 1; end
      default: ;
    endcase
    return {a_op, srca, srcb, io, mr, mw, irw, pcw, pcc, pcs, rw, rd, m2r, dn, il};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge and let outputs settle.
  task automatic cyc(input logic rdy, input logic [2:0] op);
    @(negedge clk);
    mem_ready = rdy;
    opcode    = op;
    #1;
  endtask

  typedef struct {
    logic [2:0] op;
    int         stalls;
    int         exp_cyc;
    int         exp_inc;
    logic       exp_ill;
  } vec_t;

  vec_t vt [11];
  int   exp_r  [4] = '{0, 1, 6, 7};
  int   exp_lw [7] = '{0, 1, 2, 3, 3, 3, 4};
  logic rdy_lw [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int   q [$];

  initial begin
    int n, dn_cnt, st;
    logic ill_seen, ended, r;
    logic [2:0] op;

    vt[0]  = '{3'b000, 0, 4, 1, 1'b0};
    vt[1]  = '{3'b001, 0, 5, 1, 1'b0};
    vt[2]  = '{3'b010, 0, 4, 1, 1'b0};
    vt[3]  = '{3'b011, 0, 3, 1, 1'b0};
    vt[4]  = JEN ? '{3'b100, 0, 3, 1, 1'b0} : '{3'b100, 0, 2, 0, 1'b1};
    vt[5]  = '{3'b111, 0, 2, 0, 1'b1};
    vt[6]  = '{3'b101, 0, 2, 0, 1'b1};
    vt[7]  = '{3'b110, 1, 3, 0, 1'b1};
    vt[8]  = '{3'b000, 2, 6, 1, 1'b0};
    vt[9]  = '{3'b010, 3, 7, 1, 1'b0};
    vt[10] = '{3'b001, 1, 6, 1, 1'b0};

    // Reset: everything but state forced low even with mem_ready high.
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("reset_state", state, 0);
    chk("reset_outputs", obs, 0);
    chk("reset_count", instr_count, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;

    // R-type with mem_ready high: 0,1,6,7.
    dn_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 3'b000);
      chk("r_state", state, exp_r[i]);
      chk("r_outputs", obs, exp_out(exp_r[i], 1'b1, 3'b000));
      dn_cnt += int'(instr_done);
      if (i == 2) chk("r_exec_aluop", aluop, 2'b10);
      if (i == 3) chk("r_rwb_regs", {regwrite, regdst}, 2'b11);
    end
    cyc(1'b0, 3'b000);
    chk("r_done_pulses", dn_cnt, 1);
    chk("r_count", instr_count, 1);
    mcnt = 1;

    // LW with two MEMRD stall cycles: 0,1,2,3,3,3,4.
    for (int i = 0; i < 7; i++) begin
      cyc(rdy_lw[i], 3'b001);
      chk("lw_state", state, exp_lw[i]);
      chk("lw_outputs", obs, exp_out(exp_lw[i], rdy_lw[i], 3'b001));
      if (exp_lw[i] == 3) chk("lw_memrd_strobes", {memread, iord}, 2'b11);
      if (i == 6) chk("lw_memtoreg", memtoreg, 1);
    end
    mcnt = 2;

    // Vector table: FETCH stalls, then run to the instruction's final cycle.
    foreach (vt[v]) begin
      n = 0; dn_cnt = 0; ill_seen = 0; ended = 0;
      for (int k = 0; k < 40 && !ended; k++) begin
        cyc(k >= vt[v].stalls, vt[v].op);
        if (k == 0) begin
          chk("vec_start_state", state, 0);
          chk("vec_start_count", instr_count, mcnt);
        end
        n++;
        dn_cnt += int'(instr_done);
        ill_seen |= illegal;
        if (instr_done || illegal) ended = 1;
      end
      chk("vec_cycles", n, vt[v].exp_cyc);
      chk("vec_done", dn_cnt, vt[v].exp_inc);
      chk("vec_illegal", ill_seen, vt[v].exp_ill);
      mcnt = (mcnt + vt[v].exp_inc) % (1 << CW);
    end

    // Reset in the middle of a stalled MEMRD.
    cyc(1'b1, 3'b001);
    cyc(1'b1, 3'b001);
    cyc(1'b1, 3'b001);
    cyc(1'b0, 3'b001);
    chk("mid_pre_state", state, 3);
    chk("mid_pre_memread", memread, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outputs", obs, 0);
    chk("mid_rst_state", state, 0);
    chk("mid_rst_count", instr_count, 0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("post_rst_state", state, 0);
    chk("post_rst_outputs", obs, exp_out(0, 1'b0, 3'b000));
    cyc(1'b0, 3'b001);
    chk("post_rst_state2", state, 0);
    chk("post_rst_count", instr_count, 0);
    mcnt = 0;

    // Randomized run: the model holds the pending state sequence of the current instruction.
    q = '{0, 1};
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      cyc(r, op);
      st = q[0];
      chk("rnd_state", state, st);
      chk("rnd_outputs", obs, exp_out(st, r, op));
      chk("rnd_count", instr_count, mcnt);
      if (!((st == 0 || st == 3 || st == 5) && !r)) begin
        void'(q.pop_front());
        if (st == 1) begin
          case (op)
            3'd0: q = '{6, 7};
            3'd1: q = '{2, 3, 4};
            3'd2: q = '{2, 5};
            3'd3: q = '{8};
            3'd4: if (JEN) q = '{9};
            default: ;
          endcase
        end
        if (st == 4 || st == 5 || st == 7 || st == 8 || st == 9)
          mcnt = (mcnt + 1) % (1 << CW);
        if (q.size() == 0) q = '{0, 1};
      end
    end

    // Counter wrap: 2^CW - 1 R-types, then one more.
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < (1 << CW) - 1; i++)
      for (int j = 0; j < 4; j++) cyc(1'b1, 3'b000);
    cyc(1'b0, 3'b000);
    chk("wrap_full", instr_count, (1 << CW) - 1);
    for (int j = 0; j < 4; j++) cyc(1'b1, 3'b000);
    cyc(1'b0, 3'b000);
    chk("wrap_zero", instr_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
